// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types, widths and address helpers for the data cache
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    DONE   = 3'd4
  } cache_state_t;

  localparam int OFFSET_BITS       = 2;
  localparam int MAX_AW            = 64;
  localparam int DEF_ADDRESS_WIDTH = 32;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_SET_BITS      = 3;

  function automatic int tag_bits(input int aw, input int set_bits);
    return aw - set_bits - OFFSET_BITS;
  endfunction

  localparam int TAG_BITS = tag_bits(DEF_ADDRESS_WIDTH, DEF_SET_BITS);

  // Line index: the address bits just above the byte offset.
  function automatic logic [MAX_AW-1:0] get_index(input logic [MAX_AW-1:0] addr, input int set_bits);
    return (addr >> OFFSET_BITS) & ((64'd1 << set_bits) - 64'd1);
  endfunction

  // Tag: everything above the index.
  function automatic logic [MAX_AW-1:0] get_tag(input logic [MAX_AW-1:0] addr, input int set_bits);
    return addr >> (OFFSET_BITS + set_bits);
  endfunction

  // Performance counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cache_controller_if.sv
// rtl/cache_controller_if.sv - CPU-side and memory-side signal bundle of the data cache
interface cache_controller_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);

  logic                     cpu_req;
  logic                     cpu_we;
  logic [ADDRESS_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0]    cpu_wdata;
  logic                     flush;
  logic [DATA_WIDTH-1:0]    cpu_rdata;
  logic                     cpu_ready;
  logic                     busy;
  logic                     mem_req;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem_rdata;
  logic                     mem_ack;
  logic [31:0]              hit_cnt;
  logic [31:0]              miss_cnt;

  // Environment side: the CPU requester plus the data memory responder.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, busy, mem_req, mem_we, mem_addr, mem_wdata,
    input  hit_cnt, miss_cnt
  );

  // Controller side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, busy, mem_req, mem_we, mem_addr, mem_wdata,
    output hit_cnt, miss_cnt
  );

endinterface

// File: rtl/cache_store.sv
// rtl/cache_store.sv - valid/tag/data arrays of the direct-mapped one-word-per-line cache
module cache_store
  import cache_pkg::*;
#(
  parameter int SET_BITS   = DEF_SET_BITS,
  parameter int TAG_W      = TAG_BITS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inv_all_i,
  input  logic [SET_BITS-1:0]   rd_index_i,
  output logic                  rd_valid_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  wr_en_i,
  input  logic [SET_BITS-1:0]   wr_index_i,
  input  logic [TAG_W-1:0]      wr_tag_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i
);

  localparam int LINES = 1 << SET_BITS;

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES];

  // Valid bits: cleared by reset or bulk invalidate, set by any line write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (inv_all_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bit guards their contents.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - lookup/refill/write-through sequencer for the data cache
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int SET_BITS      = DEF_SET_BITS
) (
  input  logic              clk,
  input  logic              rst,
  cache_controller_if.slave bus
);

  localparam int TAG_W = tag_bits(ADDRESS_WIDTH, SET_BITS);

  localparam logic [2:0] S_IDLE   = 3'(IDLE);
  localparam logic [2:0] S_LOOKUP = 3'(LOOKUP);
  localparam logic [2:0] S_MEM_RD = 3'(MEM_RD);
  localparam logic [2:0] S_MEM_WR = 3'(MEM_WR);
  localparam logic [2:0] S_DONE   = 3'(DONE);

  logic [2:0]               state_q, state_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    cpu_rdata_q, cpu_rdata_d;
  logic                     cpu_ready_q, cpu_ready_d;
  logic                     busy_q, busy_d;
  logic                     mem_req_q, mem_req_d;
  logic                     mem_we_q, mem_we_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [31:0]              hit_cnt_q, hit_cnt_d;
  logic [31:0]              miss_cnt_q, miss_cnt_d;

  logic [SET_BITS-1:0]   line_index;
  logic [TAG_W-1:0]      line_tag;
  logic                  st_valid;
  logic [TAG_W-1:0]      st_tag;
  logic [DATA_WIDTH-1:0] st_data;
  logic                  st_wr_en;
  logic [DATA_WIDTH-1:0] st_wr_data;
  logic                  st_inv;
  logic                  hit;

  // The latched request address drives both the store lookup and any refill.
  assign line_index = SET_BITS'(get_index(MAX_AW'(addr_q), SET_BITS));
  assign line_tag   = TAG_W'(get_tag(MAX_AW'(addr_q), SET_BITS));
  assign hit        = st_valid && (st_tag == line_tag);

  cache_store #(
    .SET_BITS   (SET_BITS),
    .TAG_W      (TAG_W),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .inv_all_i  (st_inv),
    .rd_index_i (line_index),
    .rd_valid_o (st_valid),
    .rd_tag_o   (st_tag),
    .rd_data_o  (st_data),
    .wr_en_i    (st_wr_en),
    .wr_index_i (line_index),
    .wr_tag_i   (line_tag),
    .wr_data_i  (st_wr_data)
  );

  // Next-state logic; every output register is derived from the next state so
  // the ports change together with the state they describe.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    st_wr_en    = 1'b0;
    st_wr_data  = wdata_q;
    st_inv      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.flush) begin
          st_inv = 1'b1;
        end else if (bus.cpu_req) begin
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          hit_cnt_d = sat_inc(hit_cnt_q);
        end else begin
          miss_cnt_d = sat_inc(miss_cnt_q);
        end
        mem_addr_d = {addr_q[ADDRESS_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        if (we_q) begin
          // Write-through: memory is always written; a miss does not allocate.
          mem_wdata_d = wdata_q;
          state_d     = S_MEM_WR;
          st_wr_en    = hit;
        end else if (hit) begin
          cpu_rdata_d = st_data;
          state_d     = S_DONE;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        if (bus.mem_ack) begin
          st_wr_en    = 1'b1;
          st_wr_data  = bus.mem_rdata;
          cpu_rdata_d = bus.mem_rdata;
          state_d     = S_DONE;
        end
      end
      S_MEM_WR: begin
        if (bus.mem_ack) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d      = (state_d != S_IDLE);
    cpu_ready_d = (state_d == S_DONE);
    mem_req_d   = (state_d == S_MEM_RD) || (state_d == S_MEM_WR);
    mem_we_d    = (state_d == S_MEM_WR);
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.busy      = busy_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.hit_cnt   = hit_cnt_q;
  assign bus.miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed scoreboard bench for cache_controller
module tb_cache_controller;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cache_controller_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  cache_controller #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .SET_BITS      (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        is_read;
    logic        miss;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];

  int tests = 0;
  int fails = 0;

  logic        mdl_valid [8];
  logic [26:0] mdl_tag   [8];
  logic [31:0] mdl_data  [8];
  logic [31:0] mem_model [bit [31:0]];
  logic [31:0] mdl_hits;
  logic [31:0] mdl_misses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return 32'h0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mdl_valid[i] = 1'b0;
  endtask

  // One CPU transaction: predict, push to scoreboard, act as memory, pop and compare.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_wait, input logic with_flush);
    exp_t        e;
    exp_t        got;
    int          idx;
    logic        hit;
    logic [31:0] aligned;
    int          edges;
    int          req_cycles;
    logic        started;
    logic        done;
    logic        saw_mem;

    aligned       = {addr[31:2], 2'b00};
    bus.flush     = with_flush;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    if (with_flush) begin
      @(posedge clk); #1;
      check("flush_cycle_busy", 32'(bus.busy), 32'd0);
      bus.flush = 1'b0;
      model_clear();
    end

    idx = int'(addr[4:2]);
    hit = mdl_valid[idx] && (mdl_tag[idx] == addr[31:5]);
    e.is_read = !we;
    e.miss    = !hit;
    e.rdata   = hit ? mdl_data[idx] : mem_read(aligned);
    if (hit) mdl_hits = mdl_hits + 32'd1;
    else     mdl_misses = mdl_misses + 32'd1;
    if (!we && !hit) begin
      mdl_valid[idx] = 1'b1;
      mdl_tag[idx]   = addr[31:5];
      mdl_data[idx]  = e.rdata;
    end
    if (we && hit) mdl_data[idx] = wdata;
    sb_q.push_back(e);

    edges = 0; req_cycles = 0; started = 1'b0; done = 1'b0; saw_mem = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      if (bus.busy) started = 1'b1;
      if (started) edges++;
      if (bus.cpu_ready) begin
        got = sb_q.pop_front();
        bus.cpu_req = 1'b0;
        if (got.is_read) check("cpu_rdata", bus.cpu_rdata, got.rdata);
        check("mem_used", 32'(saw_mem), 32'(got.miss || !got.is_read));
        check("mem_req_cycles", 32'(req_cycles), saw_mem ? 32'(ack_wait + 1) : 32'd0);
        check("latency", 32'(edges), (hit && !we) ? 32'd2 : 32'(3 + ack_wait));
        check("hit_cnt", bus.hit_cnt, mdl_hits);
        check("miss_cnt", bus.miss_cnt, mdl_misses);
        done = 1'b1;
      end else if (bus.mem_req) begin
        saw_mem = 1'b1;
        check("mem_addr", bus.mem_addr, aligned);
        check("mem_we", 32'(bus.mem_we), 32'(we));
        if (we) check("mem_wdata", bus.mem_wdata, wdata);
        if (req_cycles == ack_wait) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = we ? 32'h0 : mem_read(aligned);
          if (we) mem_model[aligned] = wdata;
        end
        req_cycles++;
      end
    end
    check("completed", 32'(done), 32'd1);
    bus.cpu_req = 1'b0;
    bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    check("ready_one_cycle", 32'(bus.cpu_ready), 32'd0);
  endtask

  initial begin
    rst           = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'h0;
    bus.flush     = 1'b0;
    bus.mem_rdata = 32'h0;
    bus.mem_ack   = 1'b0;
    mdl_hits      = 32'd0;
    mdl_misses    = 32'd0;
    model_clear();
    mem_model[32'h40] = 32'hDEADBEEF;
    mem_model[32'h60] = 32'h12345678;

    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_hit_cnt", bus.hit_cnt, 32'd0);
    check("rst_miss_cnt", bus.miss_cnt, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: cold read miss with a 3-cycle memory wait
    do_req(1'b0, 32'h40, 32'h0, 3, 1'b0);
    check("t1_miss_cnt", bus.miss_cnt, 32'd1);
    check("t1_rdata", bus.cpu_rdata, 32'hDEADBEEF);

    // 2: read hit
    do_req(1'b0, 32'h40, 32'h0, 0, 1'b0);
    check("t2_hit_cnt", bus.hit_cnt, 32'd1);

    // 3: conflicting tag on the same line, then back
    do_req(1'b0, 32'h60, 32'h0, 2, 1'b0);
    do_req(1'b0, 32'h40, 32'h0, 1, 1'b0);
    check("t3_miss_cnt", bus.miss_cnt, 32'd3);

    // 4: write hit with zero-wait ack, read back, then no-allocate write miss
    do_req(1'b0, 32'h60, 32'h0, 0, 1'b0);
    do_req(1'b1, 32'h60, 32'hCAFEF00D, 0, 1'b0);
    do_req(1'b0, 32'h60, 32'h0, 0, 1'b0);
    check("t4_readback", bus.cpu_rdata, 32'hCAFEF00D);
    do_req(1'b1, 32'h80, 32'h0BADC0DE, 2, 1'b0);
    do_req(1'b0, 32'h80, 32'h0, 1, 1'b0);
    check("t4_rdata_80", bus.cpu_rdata, 32'h0BADC0DE);

    // 5: flush wins over a simultaneous request; the request then misses
    do_req(1'b0, 32'h40, 32'h0, 0, 1'b0);
    do_req(1'b0, 32'h40, 32'h0, 1, 1'b1);

    // 6: reset while waiting on memory, then a stray ack in IDLE
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'hA0;
    for (int c = 0; c < 20 && !bus.mem_req; c++) begin
      @(posedge clk); #1;
    end
    check("t6_in_mem_rd", 32'(bus.mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    check("t6_rst_hit_cnt", bus.hit_cnt, 32'd0);
    check("t6_rst_miss_cnt", bus.miss_cnt, 32'd0);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    #2 rst = 1'b1;
    model_clear();
    mdl_hits   = 32'd0;
    mdl_misses = 32'd0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h55555555;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    check("t6_stray_busy", 32'(bus.busy), 32'd0);
    check("t6_stray_mem_req", 32'(bus.mem_req), 32'd0);
    check("t6_stray_ready", 32'(bus.cpu_ready), 32'd0);
    do_req(1'b0, 32'h40, 32'h0, 0, 1'b0);
    check("t6_miss_cnt", bus.miss_cnt, 32'd1);
    check("t6_hit_cnt", bus.hit_cnt, 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
